// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WPTR,
        ST_WPTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } tgt_state_t;

    // General-call address; never acknowledged by this target.
    localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;

    // clk cycles from rd_req to rd_data capture when not clock stretching.
    localparam logic [1:0] I2C_RD_LAT = 2'd2;

endpackage

// File: rtl/i2c_line_filt.sv
// Input conditioning for one open-drain line: 2-flop synchronizer, a
// FILT-sample stability filter and registered rise/fall pulses of the
// filtered level. Everything resets to the idle (high) bus level.
module i2c_line_filt #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_raw,
    output logic line_f,
    output logic line_rise,
    output logic line_fall
);

    localparam logic [2:0] CNT_MAX = 3'(FILT - 1);

    logic [1:0] sync;
    logic [2:0] cnt;

    // Synchronize, then accept a new level only after FILT identical samples.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            cnt       <= '0;
            line_f    <= 1'b1;
            line_rise <= 1'b0;
            line_fall <= 1'b0;
        end else begin
            sync      <= {sync[0], line_raw};
            line_rise <= 1'b0;
            line_fall <= 1'b0;
            if (sync[1] != line_f) begin
                if (cnt == CNT_MAX) begin
                    line_f    <= sync[1];
                    line_rise <= sync[1];
                    line_fall <= ~sync[1];
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: START/STOP detection, 7-bit address match and a
// byte-wide register-file port (pointer write, data write, sequential read).
// Optional feature: define I2C_TGT_STRETCH_EN to stretch SCL while waiting
// for rd_ack; otherwise rd_data is captured a fixed I2C_RD_LAT after rd_req.
module i2c_target
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         FILT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] reg_addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    input  logic       rd_ack,
    output logic       busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    tgt_state_t state;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       inc_pend;

    i2c_line_filt #(.FILT(FILT)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line_raw(scl_in),
        .line_f(scl_f), .line_rise(scl_rise), .line_fall(scl_fall)
    );

    i2c_line_filt #(.FILT(FILT)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line_raw(sda_in),
        .line_f(sda_f), .line_rise(sda_rise), .line_fall(sda_fall)
    );

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

`ifdef I2C_TGT_STRETCH_EN
    logic stretch;
    logic rel_pend;
`else
    logic [1:0] lat_cnt;
    logic       unused_rd_ack;
    assign unused_rd_ack = rd_ack;
    assign scl_oe        = 1'b0;
`endif

    // Bus protocol FSM with registered line drivers and register-file strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            inc_pend <= 1'b0;
            sda_oe   <= 1'b0;
            reg_addr <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
            scl_oe   <= 1'b0;
            stretch  <= 1'b0;
            rel_pend <= 1'b0;
`else
            lat_cnt  <= '0;
`endif
        end else begin
            wr_en  <= 1'b0;
            rd_req <= 1'b0;

            // Pointer advance one clk after a data-byte write strobe.
            if (inc_pend) begin
                reg_addr <= reg_addr + 8'd1;
                inc_pend <= 1'b0;
            end

`ifdef I2C_TGT_STRETCH_EN
            if (rel_pend) begin
                scl_oe   <= 1'b0;
                rel_pend <= 1'b0;
            end
            // Capture read data when the register file answers; the first
            // bit goes out while SCL is still held low by this target.
            if (stretch && rd_ack) begin
                shreg    <= rd_data;
                reg_addr <= reg_addr + 8'd1;
                sda_oe   <= ~rd_data[7];
                stretch  <= 1'b0;
                rel_pend <= 1'b1;
            end
`else
            if (lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
                if (lat_cnt == 2'd1) begin
                    shreg    <= rd_data;
                    reg_addr <= reg_addr + 8'd1;
                end
            end
`endif

            if (start_det || stop_det) begin
                // Abort any partial byte and release the bus.
                state   <= start_det ? ST_ADDR : ST_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
                scl_oe   <= 1'b0;
                stretch  <= 1'b0;
                rel_pend <= 1'b0;
`else
                lat_cnt <= '0;
`endif
            end else begin
                case (state)
                    ST_ADDR, ST_WPTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == ST_WPTR) begin
                                    reg_addr <= {shreg[6:0], sda_f};
                                end
                                if (state == ST_WDATA) begin
                                    wr_en    <= 1'b1;
                                    wr_data  <= {shreg[6:0], sda_f};
                                    inc_pend <= 1'b1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ST_ADDR) begin
                                if (shreg[7:1] == ADDR && shreg[7:1] != I2C_GCALL_ADDR) begin
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    rw     <= shreg[0];
                                    state  <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                sda_oe <= 1'b1;
                                state  <= (state == ST_WPTR) ? ST_WPTR_ACK : ST_WDATA_ACK;
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_RACK: begin
                        if (scl_rise && state == ST_RACK && sda_f) begin
                            // Master NACK ends the read.
                            state <= ST_IGNORE;
                            busy  <= 1'b0;
`ifndef I2C_TGT_STRETCH_EN
                        end else if (scl_rise && rw) begin
                            rd_req  <= 1'b1;
                            lat_cnt <= I2C_RD_LAT;
`endif
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                state <= ST_RDATA;
`ifdef I2C_TGT_STRETCH_EN
                                sda_oe  <= 1'b0;
                                rd_req  <= 1'b1;
                                scl_oe  <= 1'b1;
                                stretch <= 1'b1;
`else
                                sda_oe <= ~shreg[7];
`endif
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WPTR;
                            end
                        end
                    end

                    ST_WPTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WDATA;
                        end
                    end

                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_RACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end

                    ST_IDLE, ST_IGNORE: ;

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for the on-board I2C bus. It is the far end of the open-drain master path and attaches to the board's existing open-drain SDA/SCL pad buffers through their `sda_in`/`scl_in`/`sda_oe`/`scl_oe` pins. It decodes START, STOP and address, acknowledges its own 7-bit address, and maps bus transfers onto a simple 8-bit register-file port. It runs entirely on the system clock and oversamples SCL and SDA.

## Interface
- `ADDR`, default 7'h50: 7-bit target address.
- `FILT`, default 3: glitch-filter depth in clk cycles. Legal range 1..7.
- `clk` in 1: system clock. Must be at least 20x the SCL frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `sda_in` in 1: raw SDA level from the pad buffer.
- `scl_in` in 1: raw SCL level from the pad buffer.
- `sda_oe` out 1: 1 pulls SDA low.
- `scl_oe` out 1: 1 pulls SCL low. Used for clock stretching only.
- `reg_addr` out 8: register pointer.
- `wr_en` out 1: one-cycle write strobe.
- `wr_data` out 8: write data. Valid while `wr_en` is 1.
- `rd_req` out 1: one-cycle read request for `reg_addr`.
- `rd_data` in 8: read data from the register file.
- `rd_ack` in 1: read data valid. Used only when `I2C_TGT_STRETCH_EN` is defined.
- `busy` out 1: high from an address match until STOP, repeated START, or NACK-idle.

## Operation
**Input conditioning**
- Each line passes through a 2-flop synchronizer, then a FILT-cycle stability filter. A filtered level changes only after FILT identical consecutive samples.
- The edge detector works on the filtered SCL (`scl_f`) and filtered SDA (`sda_f`).
- START: `sda_f` falls while `scl_f` is 1. STOP: `sda_f` rises while `scl_f` is 1.
- Bits are sampled on the rising edge of `scl_f`, MSB first.

**States**
- IDLE: waiting for START.
- ADDR: shifting in 8 bits.
- ADDR_ACK:
  - Address match: drive ACK.
  - Mismatch or general call (7'h00): go to IGNORE.
- WPTR / WPTR_ACK: receive the first write byte into `reg_addr`, then ACK.
- WDATA / WDATA_ACK: receive a data byte, pulse `wr_en`, then ACK.
- RDATA: shift out the loaded byte.
- RACK: sample the master's ACK/NACK.
  - ACK: load the next byte and return to RDATA.
  - NACK: go to IGNORE.
- IGNORE: release both lines and wait for START/STOP.

**Register transfers**
- `wr_en` pulses on the clk after the 8th data bit is sampled, with `wr_data` set to that byte.
- `reg_addr` increments on the following clk.
- The pointer is not incremented after a WPTR byte.
- A read loads the byte at `reg_addr`; `reg_addr` increments after the load.
- `reg_addr` wraps from 8'hFF to 8'h00.
- `reg_addr` persists across transactions. This supports the write-pointer, Sr, read sequence.

**Boundary conditions**
- START or STOP in any state aborts the current byte.
  - A partial byte never produces `wr_en` and never moves the pointer.
  - START goes to ADDR. STOP goes to IDLE.
- Both lines are released on abort.
- The target never ACKs a mismatched address and never drives SDA in IGNORE.
- `rst_n` asserted mid-transfer releases both lines immediately, asynchronously. The FSM returns to IDLE.

## Timing
- Reset values:
  - `sda_oe`=0, `scl_oe`=0, `wr_en`=0, `rd_req`=0, `busy`=0.
  - `reg_addr`=8'h00, `wr_data`=8'h00.
  - FSM in IDLE.
  - Filters preset to 1.
- Input latency: 2 + FILT clk cycles from pad to `scl_f`/`sda_f`.
- Output changes:
  - `sda_oe` changes only on the clk after an `scl_f` falling edge. This gives data hold after SCL falls.
  - `sda_oe` is held through the SCL high phase.
- ACK: `sda_oe`=1 from the fall of SCL after bit 8 until the next SCL fall.
- Read without stretching:
  - `rd_req` pulses one clk after the `scl_f` rise of the ACK bit.
  - `rd_data` is latched into the shift register 2 clk after `rd_req`.
  - The latched byte is presented from the following SCL fall.
- Output behaviour: all outputs are registered, with no combinational path from `rd_data` or `rd_ack` to any output.

## Configuration
- `I2C_TGT_STRETCH_EN` defined:
  - `rd_req` pulses one clk after the `scl_f` fall that ends an ACK bit.
  - At the same time `scl_oe` goes to 1.
  - On the clk where `rd_ack`=1, `rd_data` is latched. `scl_oe` returns to 0 on the next clk.
  - `rd_ack` asserted in the same cycle as `rd_req` is legal and accepted.
  - STOP, START or reset while stretching releases `scl_oe`.
- Not defined:
  - `scl_oe` is tied to 0 and `rd_ack` is ignored.
  - The fixed 2-clk read latency from Timing applies.

## Structure
- Package `i2c_tgt_pkg`:
  - FSM state enum.
  - Constant `I2C_GCALL_ADDR` = 7'h00.
  - Constant for read latency = 2.
- Sub-module `i2c_line_filt`:
  - Contents: synchronizer, FILT filter, rise/fall pulses.
  - Instantiated once each for SCL and SDA.
- START/STOP detection and the FSM live in `i2c_target`.

## Test plan
- Reset released with no bus activity -> all outputs hold their reset values, and `sda_oe` stays 0 for 1000 clk.
- Write 0xA0, 0x10, 0x5A, 0x3C -> ACK on every byte. `wr_en` pulses at `reg_addr` 0x10 with data 0x5A, then at 0x11 with data 0x3C. Final `reg_addr` = 0x12.
- Write 0xA0, 0xFF, then Sr, 0xA1, read 2 bytes (ACK, then NACK), with the register model returning 0x11 then 0x22 -> master reads 0x11, 0x22. `rd_req` fires at `reg_addr` 0xFF, then 0x00 (wrap).
- Address 0xA2 and general call 0x00 -> SDA never pulled low, no strobes, `busy`=0.
- STOP injected after 4 bits of a data byte -> no `wr_en`, `reg_addr` unchanged, FSM in IDLE. A following valid write succeeds.
- Stretch build with `rd_ack` delayed 50 clk -> `scl_oe`=1 for 51 clk, and the returned byte is shifted correctly. A 2-clk SDA glitch with FILT=3 produces no false START.
